// File: rtl/core_pkg.sv
// Shared definitions for the core's memory-side blocks.
// Holds the arbiter state encoding and the byte-enable width.
package core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_IF,
        ADDR_DM,
        RESP_IF,
        RESP_DM
    } arb_state_t;

    localparam int ARB_BE_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Ports: Clk_Core, Rst_Core_N; IF_* fetch side (Req/Addr in, Gnt/Rvalid/Rdata out);
// DM_* data side (Req/We/Be/Addr/Wdata in, Gnt/Rvalid/Rdata out);
// Mem_* memory side (Req/We/Be/Addr/Wdata out, Gnt/Rvalid/Rdata in).
module mem_arbiter
    import core_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                Clk_Core,
    input  logic                Rst_Core_N,
    input  logic                IF_Req,
    input  logic [AWIDTH-1:0]   IF_Addr,
    output logic                IF_Gnt,
    output logic                IF_Rvalid,
    output logic [DWIDTH-1:0]   IF_Rdata,
    input  logic                DM_Req,
    input  logic                DM_We,
    input  logic [ARB_BE_W-1:0] DM_Be,
    input  logic [AWIDTH-1:0]   DM_Addr,
    input  logic [DWIDTH-1:0]   DM_Wdata,
    output logic                DM_Gnt,
    output logic                DM_Rvalid,
    output logic [DWIDTH-1:0]   DM_Rdata,
    output logic                Mem_Req,
    output logic                Mem_We,
    output logic [ARB_BE_W-1:0] Mem_Be,
    output logic [AWIDTH-1:0]   Mem_Addr,
    output logic [DWIDTH-1:0]   Mem_Wdata,
    input  logic                Mem_Gnt,
    input  logic                Mem_Rvalid,
    input  logic [DWIDTH-1:0]   Mem_Rdata
);

    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic [SW-1:0] starve_q;
    logic          dm_we_q;
    logic          drv_if;
    logic          drv_dm;
    logic          if_take;
    logic          dm_take;
    logic          if_starved;

    // Fetch wins over data only once data has used up its grant budget.
    assign if_starved = IF_Req && (starve_q == STARVE_MAX);

    always_comb begin
        state_d = state_q;
        drv_if  = 1'b0;
        drv_dm  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (DM_Req && !if_starved) begin
                    drv_dm  = 1'b1;
                    state_d = Mem_Gnt ? RESP_DM : ADDR_DM;
                end else if (IF_Req) begin
                    drv_if  = 1'b1;
                    state_d = Mem_Gnt ? RESP_IF : ADDR_IF;
                end
            end
            // A dropped request here is a protocol error: release the bus.
            ADDR_IF: begin
                if (IF_Req) begin
                    drv_if = 1'b1;
                    if (Mem_Gnt) state_d = RESP_IF;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR_DM: begin
                if (DM_Req) begin
                    drv_dm = 1'b1;
                    if (Mem_Gnt) state_d = RESP_DM;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP_IF, RESP_DM: begin
                if (Mem_Rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_take = drv_if & Mem_Gnt;
    assign dm_take = drv_dm & Mem_Gnt;
    assign IF_Gnt  = if_take;
    assign DM_Gnt  = dm_take;

    // Fetches are full-word reads; unselected fields stay at zero.
    assign Mem_Req   = drv_if | drv_dm;
    assign Mem_We    = drv_dm & DM_We;
    assign Mem_Be    = drv_dm ? DM_Be :
                       (drv_if ? {ARB_BE_W{1'b1}} : '0);
    assign Mem_Addr  = drv_dm ? DM_Addr :
                       (drv_if ? IF_Addr : '0);
    assign Mem_Wdata = drv_dm ? DM_Wdata : '0;

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state_q  <= IDLE;
            starve_q <= '0;
            dm_we_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (dm_take) begin
                dm_we_q <= DM_We;
                if (!IF_Req) begin
                    starve_q <= '0;
                end else if (starve_q != STARVE_MAX) begin
                    starve_q <= starve_q + 1'b1;
                end
            end else if (if_take) begin
                starve_q <= '0;
            end
        end
    end

    // Responses are only accepted in a RESP state; anything else is spurious.
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            IF_Rvalid <= 1'b0;
            DM_Rvalid <= 1'b0;
            IF_Rdata  <= '0;
            DM_Rdata  <= '0;
        end else begin
            IF_Rvalid <= (state_q == RESP_IF) && Mem_Rvalid;
            DM_Rvalid <= (state_q == RESP_DM) && Mem_Rvalid;
            if ((state_q == RESP_IF) && Mem_Rvalid) begin
                IF_Rdata <= Mem_Rdata;
            end
            // Stores complete with a pulse but leave load data untouched.
            if ((state_q == RESP_DM) && Mem_Rvalid && !dm_we_q) begin
                DM_Rdata <= Mem_Rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model.
// Directed scenarios first, then random requesters and a random memory.
module tb_mem_arbiter;

    localparam int MAX_STARVE = 4;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks;
    int errs;

    // Reference model: who holds the bus, who awaits data, starvation tally.
    int          own;
    int          wt;
    bit          wt_st;
    int          starve;
    int          sel;
    bit          e_if_rv;
    bit          e_dm_rv;
    logic [31:0] e_if_rd;
    logic [31:0] e_dm_rd;
    bit          g_if;
    bit          g_dm;
    int          mem_cnt;
    logic [31:0] prev_rd;

    mem_arbiter #(
        .DWIDTH(32),
        .AWIDTH(32),
        .MAX_STARVE(MAX_STARVE)
    ) dut (
        .Clk_Core(clk),
        .Rst_Core_N(rst_n),
        .IF_Req(if_req),
        .IF_Addr(if_addr),
        .IF_Gnt(if_gnt),
        .IF_Rvalid(if_rvalid),
        .IF_Rdata(if_rdata),
        .DM_Req(dm_req),
        .DM_We(dm_we),
        .DM_Be(dm_be),
        .DM_Addr(dm_addr),
        .DM_Wdata(dm_wdata),
        .DM_Gnt(dm_gnt),
        .DM_Rvalid(dm_rvalid),
        .DM_Rdata(dm_rdata),
        .Mem_Req(mem_req),
        .Mem_We(mem_we),
        .Mem_Be(mem_be),
        .Mem_Addr(mem_addr),
        .Mem_Wdata(mem_wdata),
        .Mem_Gnt(mem_gnt),
        .Mem_Rvalid(mem_rvalid),
        .Mem_Rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag,
                            input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own     = 0;
        wt      = 0;
        wt_st   = 0;
        starve  = 0;
        e_if_rv = 0;
        e_dm_rv = 0;
        e_if_rd = '0;
        e_dm_rd = '0;
        g_if    = 0;
        g_dm    = 0;
    endtask

    task automatic idle_inputs();
        if_req     = 0;
        dm_req     = 0;
        dm_we      = 0;
        mem_gnt    = 0;
        mem_rvalid = 0;
    endtask

    // Called just after a posedge with inputs driven; checks at negedge,
    // advances the model, returns just after the next posedge.
    task automatic step();
        logic [31:0] e_addr;
        bit          if_ok;
        bit          dm_ok;
        @(negedge clk);
        sel = 0;
        if (wt == 0) begin
            if (own != 0) begin
                if_ok = (own == 1) && if_req;
                dm_ok = (own == 2) && dm_req;
                sel = (if_ok || dm_ok) ? own : 0;
            end else if (dm_req &&
                         !(if_req && starve == MAX_STARVE)) begin
                sel = 2;
            end else if (if_req) begin
                sel = 1;
            end
        end
        e_addr = (sel == 2) ? dm_addr :
                 ((sel == 1) ? if_addr : 32'h0);
        check_eq("mem_req", 32'(mem_req), 32'(sel != 0));
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("mem_we", 32'(mem_we), 32'((sel == 2) && dm_we));
        if (sel != 1) begin
            check_eq("mem_be", 32'(mem_be),
                     (sel == 2) ? 32'(dm_be) : 32'h0);
            check_eq("mem_wdata", mem_wdata,
                     (sel == 2) ? dm_wdata : 32'h0);
        end
        check_eq("if_gnt", 32'(if_gnt), 32'((sel == 1) && mem_gnt));
        check_eq("dm_gnt", 32'(dm_gnt), 32'((sel == 2) && mem_gnt));
        check_eq("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
        check_eq("if_rdata", if_rdata, e_if_rd);
        check_eq("dm_rvalid", 32'(dm_rvalid), 32'(e_dm_rv));
        check_eq("dm_rdata", dm_rdata, e_dm_rd);
        g_if    = (sel == 1) && mem_gnt;
        g_dm    = (sel == 2) && mem_gnt;
        e_if_rv = (wt == 1) && mem_rvalid;
        e_dm_rv = (wt == 2) && mem_rvalid;
        if (e_if_rv) e_if_rd = mem_rdata;
        if (e_dm_rv && !wt_st) e_dm_rd = mem_rdata;
        if (wt != 0) begin
            if (mem_rvalid) wt = 0;
        end else if (sel != 0 && mem_gnt) begin
            wt    = sel;
            wt_st = (sel == 2) && dm_we;
            own   = 0;
            if (sel == 1 || !if_req) starve = 0;
            else if (starve < MAX_STARVE) starve++;
        end else begin
            own = sel;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input int dm_pct);
        if (g_if) if_req = 0;
        if (!if_req && $urandom_range(99, 0) < 40) begin
            if_req  = 1;
            if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (g_dm) dm_req = 0;
        if (!dm_req && $urandom_range(99, 0) < dm_pct) begin
            dm_req   = 1;
            dm_we    = $urandom_range(1, 0) == 1;
            dm_be    = 4'($urandom_range(15, 0));
            dm_addr  = $urandom & 32'hFFFF_FFFC;
            dm_wdata = $urandom;
        end
        mem_rvalid = 0;
        if (mem_cnt > 0) mem_cnt--;
        if (mem_cnt == 0) begin
            mem_rvalid = 1;
            mem_rdata  = $urandom;
            mem_cnt    = -1;
        end else if (mem_cnt < 0 && $urandom_range(7, 0) == 0) begin
            mem_rvalid = 1;
            mem_rdata  = $urandom;
        end
        mem_gnt = $urandom_range(99, 0) < 60;
    endtask

    initial begin
        checks   = 0;
        errs     = 0;
        mem_cnt  = -1;
        if_addr  = '0;
        dm_be    = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        mem_rdata = '0;
        idle_inputs();
        model_reset();
        rst_n = 0;
        #2;
        check_eq("rst_mem_req", 32'(mem_req), 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_if_rv", 32'(if_rvalid), 32'h0);
        check_eq("rst_dm_rv", 32'(dm_rvalid), 32'h0);
        check_eq("rst_if_rd", if_rdata, 32'h0);
        check_eq("rst_dm_rd", dm_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // Single fetch: grant in cycle 0, data back in cycle 2.
        if_req  = 1;
        if_addr = 32'h100;
        mem_gnt = 1;
        #1;
        check_eq("sf_gnt", 32'(if_gnt), 32'h1);
        step();
        if_req     = 0;
        mem_gnt    = 0;
        mem_rvalid = 1;
        mem_rdata  = 32'h0050_0093;
        step();
        mem_rvalid = 0;
        #1;
        check_eq("sf_rvalid", 32'(if_rvalid), 32'h1);
        check_eq("sf_rdata", if_rdata, 32'h0050_0093);
        check_eq("sf_dm_rv", 32'(dm_rvalid), 32'h0);
        step();

        // Collision: data first, fetch at the next idle slot.
        if_req  = 1;
        if_addr = 32'h400;
        dm_req  = 1;
        dm_we   = 0;
        dm_addr = 32'h2000;
        mem_gnt = 1;
        #1;
        check_eq("col_addr", mem_addr, 32'h2000);
        check_eq("col_dm_gnt", 32'(dm_gnt), 32'h1);
        step();
        dm_req     = 0;
        mem_gnt    = 0;
        mem_rvalid = 1;
        mem_rdata  = 32'h1111_2222;
        step();
        mem_rvalid = 0;
        mem_gnt    = 1;
        #1;
        check_eq("col_if_gnt", 32'(if_gnt), 32'h1);
        check_eq("col_if_addr", mem_addr, 32'h400);
        step();
        if_req     = 0;
        mem_gnt    = 0;
        mem_rvalid = 1;
        mem_rdata  = 32'h3333_4444;
        step();
        idle_inputs();
        step();

        // Starvation: four data grants, then the waiting fetch.
        for (int k = 0; k < 5; k++) begin
            if_req     = 1;
            dm_req     = 1;
            dm_addr    = 32'h5000 + 32'(k * 4);
            mem_gnt    = 1;
            mem_rvalid = 0;
            #1;
            check_eq($sformatf("stv_pick%0d", k),
                     {30'h0, if_gnt, dm_gnt},
                     (k < 4) ? 32'h1 : 32'h2);
            step();
            if (k == 4) if_req = 0;
            mem_gnt    = 0;
            mem_rvalid = 1;
            mem_rdata  = 32'hA000_0000 + 32'(k);
            step();
        end
        if_req     = 1;
        mem_gnt    = 1;
        mem_rvalid = 0;
        #1;
        check_eq("stv_clear", {30'h0, if_gnt, dm_gnt}, 32'h1);
        step();
        idle_inputs();
        mem_rvalid = 1;
        step();
        idle_inputs();
        step();

        // Lock: fetch keeps the bus while memory stalls.
        if_req  = 1;
        if_addr = 32'h500;
        step();
        dm_req  = 1;
        dm_we   = 0;
        dm_addr = 32'h600;
        #1;
        check_eq("lk_addr1", mem_addr, 32'h500);
        check_eq("lk_dm_gnt", 32'(dm_gnt), 32'h0);
        step();
        step();
        mem_gnt = 1;
        #1;
        check_eq("lk_if_gnt", 32'(if_gnt), 32'h1);
        check_eq("lk_addr4", mem_addr, 32'h500);
        step();
        if_req     = 0;
        mem_gnt    = 0;
        mem_rvalid = 1;
        mem_rdata  = 32'h5555_6666;
        step();
        mem_rvalid = 0;
        mem_gnt    = 1;
        #1;
        check_eq("lk_dm_after", 32'(dm_gnt), 32'h1);
        check_eq("lk_dm_addr", mem_addr, 32'h600);
        step();
        dm_req     = 0;
        mem_gnt    = 0;
        mem_rvalid = 1;
        mem_rdata  = 32'hCAFE_F00D;
        step();
        idle_inputs();
        step();

        // Store: fields forwarded, load data preserved.
        prev_rd  = dm_rdata;
        dm_req   = 1;
        dm_we    = 1;
        dm_be    = 4'hF;
        dm_wdata = 32'hDEAD_BEEF;
        dm_addr  = 32'h3000;
        mem_gnt  = 1;
        #1;
        check_eq("st_we", 32'(mem_we), 32'h1);
        check_eq("st_be", 32'(mem_be), 32'hF);
        check_eq("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        dm_req     = 0;
        mem_gnt    = 0;
        mem_rvalid = 1;
        mem_rdata  = 32'h1234_5678;
        step();
        idle_inputs();
        #1;
        check_eq("st_rvalid", 32'(dm_rvalid), 32'h1);
        check_eq("st_keep", dm_rdata, 32'hCAFE_F00D);
        check_eq("st_prev", dm_rdata, prev_rd);
        step();

        // Reset while a load response is pending.
        dm_req  = 1;
        dm_we   = 0;
        dm_addr = 32'h4000;
        mem_gnt = 1;
        step();
        idle_inputs();
        #1;
        rst_n = 0;
        #1;
        model_reset();
        check_eq("mr_req", 32'(mem_req), 32'h0);
        check_eq("mr_if_rv", 32'(if_rvalid), 32'h0);
        check_eq("mr_dm_rv", 32'(dm_rvalid), 32'h0);
        check_eq("mr_if_rd", if_rdata, 32'h0);
        check_eq("mr_dm_rd", dm_rdata, 32'h0);
        step();
        rst_n = 1;
        step();
        mem_rvalid = 1;
        mem_rdata  = 32'h7777_8888;
        step();
        mem_rvalid = 0;
        #1;
        check_eq("mr_spur", 32'(dm_rvalid), 32'h0);
        step();

        // Random traffic, then heavy data pressure to exercise starvation.
        mem_cnt = -1;
        for (int c = 0; c < 1500; c++) begin
            drive_rand((c < 800) ? 50 : 95);
            step();
            if (g_if || g_dm) mem_cnt = $urandom_range(3, 1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
